// File: rtl/occupancy_monitor.sv
// Doorway occupancy counter driven by a two-beam (outer a, inner b) sensor FSM.
// Optional packed-BCD mirror of the count is built when OCC_BCD_EN is defined.
module occupancy_monitor #(
    parameter int W        = 8,
    parameter int CAPACITY = 200
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         a,
    input  logic         b,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         enter_tick,
    output logic         exit_tick,
    output logic         seq_err,
    output logic         full,
    output logic         empty,
    output logic         overflow,
    output logic         underflow,
    output logic [11:0]  bcd
);

    localparam logic [W-1:0] CAP = W'(CAPACITY);

    typedef enum logic [2:0] {
        IDLE, EN1, EN2, EN3, EX1, EX2, EX3, ERR
    } state_t;

    state_t       r_state;
    logic         r_enter_tick;
    logic         r_exit_tick;
    logic         r_seq_err;
    logic [W-1:0] r_count;
    logic         r_overflow;
    logic         r_underflow;
    logic [1:0]   w_s;
    logic         w_in_done;
    logic         w_out_done;

    assign w_s        = {a, b};
    assign w_in_done  = (r_state == EN3) && (w_s == 2'b00);
    assign w_out_done = (r_state == EX3) && (w_s == 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_enter_tick <= 1'b0;
            r_exit_tick  <= 1'b0;
            r_seq_err    <= 1'b0;
        end else begin
            r_enter_tick <= 1'b0;
            r_exit_tick  <= 1'b0;
            r_seq_err    <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    unique case (w_s)
                        2'b10:   r_state <= EN1;
                        2'b01:   r_state <= EX1;
                        2'b11: begin
                            r_state   <= ERR;
                            r_seq_err <= 1'b1;
                        end
                        default: r_state <= IDLE;
                    endcase
                end
                EN1: begin
                    unique case (w_s)
                        2'b10:   r_state <= EN1;
                        2'b11:   r_state <= EN2;
                        2'b00:   r_state <= IDLE;
                        default: begin
                            r_state   <= ERR;
                            r_seq_err <= 1'b1;
                        end
                    endcase
                end
                EN2: begin
                    unique case (w_s)
                        2'b11:   r_state <= EN2;
                        2'b01:   r_state <= EN3;
                        2'b10:   r_state <= EN1;
                        default: begin
                            r_state   <= ERR;
                            r_seq_err <= 1'b1;
                        end
                    endcase
                end
                EN3: begin
                    unique case (w_s)
                        2'b01:   r_state <= EN3;
                        2'b00: begin
                            r_state      <= IDLE;
                            r_enter_tick <= 1'b1;
                        end
                        2'b11:   r_state <= EN2;
                        default: begin
                            r_state   <= ERR;
                            r_seq_err <= 1'b1;
                        end
                    endcase
                end
                EX1: begin
                    unique case (w_s)
                        2'b01:   r_state <= EX1;
                        2'b11:   r_state <= EX2;
                        2'b00:   r_state <= IDLE;
                        default: begin
                            r_state   <= ERR;
                            r_seq_err <= 1'b1;
                        end
                    endcase
                end
                EX2: begin
                    unique case (w_s)
                        2'b11:   r_state <= EX2;
                        2'b10:   r_state <= EX3;
                        2'b01:   r_state <= EX1;
                        default: begin
                            r_state   <= ERR;
                            r_seq_err <= 1'b1;
                        end
                    endcase
                end
                EX3: begin
                    unique case (w_s)
                        2'b10:   r_state <= EX3;
                        2'b00: begin
                            r_state     <= IDLE;
                            r_exit_tick <= 1'b1;
                        end
                        2'b11:   r_state <= EX2;
                        default: begin
                            r_state   <= ERR;
                            r_seq_err <= 1'b1;
                        end
                    endcase
                end
                default: begin
                    // ERR: wait for both beams clear before re-arming
                    if (w_s == 2'b00) r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (w_in_done) begin
            if (r_count == CAP) r_overflow <= 1'b1;
            else                r_count    <= r_count + 1'b1;
        end else if (w_out_done) begin
            if (r_count == '0) r_underflow <= 1'b1;
            else               r_count     <= r_count - 1'b1;
        end
    end

`ifdef OCC_BCD_EN
    logic [11:0] r_bcd;

    function automatic logic [11:0] f_bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (r[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            if (r[7:4] == 4'd9) begin
                r[7:4]  = 4'd0;
                r[11:8] = r[11:8] + 4'd1;
            end else begin
                r[7:4] = r[7:4] + 4'd1;
            end
        end else begin
            r[3:0] = r[3:0] + 4'd1;
        end
        return r;
    endfunction

    function automatic logic [11:0] f_bcd_dec(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (r[3:0] == 4'd0) begin
            r[3:0] = 4'd9;
            if (r[7:4] == 4'd0) begin
                r[7:4]  = 4'd9;
                r[11:8] = r[11:8] - 4'd1;
            end else begin
                r[7:4] = r[7:4] - 4'd1;
            end
        end else begin
            r[3:0] = r[3:0] - 4'd1;
        end
        return r;
    endfunction

    // Saturation keys off the binary count so both stay in lockstep
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_bcd <= 12'h000;
        end else if (w_in_done && (r_count != CAP)) begin
            r_bcd <= f_bcd_inc(r_bcd);
        end else if (w_out_done && (r_count != '0)) begin
            r_bcd <= f_bcd_dec(r_bcd);
        end
    end

    assign bcd = r_bcd;
`else
    assign bcd = 12'h000;
`endif

    assign count      = r_count;
    assign enter_tick = r_enter_tick;
    assign exit_tick  = r_exit_tick;
    assign seq_err    = r_seq_err;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;
    assign full       = (r_count == CAP);
    assign empty      = (r_count == '0);

endmodule

// File: tb/tb_occupancy_monitor.sv
// Self-checking bench for occupancy_monitor: directed scenarios plus
// randomized sensor traffic compared against a table-driven walk model.
module tb_occupancy_monitor;

    localparam int W   = 8;
    localparam int CAP = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         a = 1'b0;
    logic         b = 1'b0;
    logic         clr = 1'b0;
    logic [W-1:0] count;
    logic         enter_tick, exit_tick, seq_err;
    logic         full, empty, overflow, underflow;
    logic [11:0]  bcd;

    int errors = 0;
    int checks = 0;
    int n_ent = 0;
    int n_ext = 0;
    int n_err = 0;

    // model: position along an entry/exit pattern, plus error hold
    int m_step = 0;
    bit m_dir = 1'b0;
    bit m_err = 1'b0;
    int m_cnt = 0;
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;
    bit m_ent = 1'b0;
    bit m_ext = 1'b0;
    bit m_serr = 1'b0;

    occupancy_monitor #(.W(W), .CAPACITY(CAP)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .clr(clr),
        .count(count), .enter_tick(enter_tick), .exit_tick(exit_tick),
        .seq_err(seq_err), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow), .bcd(bcd)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] pat(input bit dir, input int k);
        logic [1:0] v;
        case (k)
            0:       v = 2'b10;
            1:       v = 2'b11;
            2:       v = 2'b01;
            default: v = 2'b00;
        endcase
        return dir ? {v[0], v[1]} : v;
    endfunction

    function automatic logic [11:0] exp_bcd(input int c);
        logic [11:0] r;
`ifdef OCC_BCD_EN
        r[11:8] = 4'(c / 100);
        r[7:4]  = 4'((c / 10) % 10);
        r[3:0]  = 4'(c % 10);
`else
        r = 12'h000;
        if (c < 0) r = 12'hfff;
`endif
        return r;
    endfunction

    task automatic model_step(input logic [1:0] s, input logic c, input logic r);
        m_ent = 1'b0;
        m_ext = 1'b0;
        m_serr = 1'b0;
        if (r) begin
            m_step = 0; m_err = 1'b0; m_cnt = 0;
            m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            if (m_err) begin
                if (s == 2'b00) m_err = 1'b0;
            end else if (m_step == 0) begin
                if (s == pat(1'b0, 0)) begin
                    m_dir = 1'b0; m_step = 1;
                end else if (s == pat(1'b1, 0)) begin
                    m_dir = 1'b1; m_step = 1;
                end else if (s == 2'b11) begin
                    m_err = 1'b1; m_serr = 1'b1;
                end
            end else if (s == pat(m_dir, m_step - 1)) begin
                m_step = m_step;
            end else if (s == pat(m_dir, m_step)) begin
                if (m_step == 3) begin
                    m_step = 0;
                    if (m_dir) m_ext = 1'b1;
                    else       m_ent = 1'b1;
                end else begin
                    m_step = m_step + 1;
                end
            end else if (m_step == 1 && s == 2'b00) begin
                m_step = 0;
            end else if (m_step >= 2 && s == pat(m_dir, m_step - 2)) begin
                m_step = m_step - 1;
            end else begin
                m_step = 0; m_err = 1'b1; m_serr = 1'b1;
            end
            if (m_ent) begin
                if (m_cnt == CAP) m_ovf = 1'b1;
                else              m_cnt = m_cnt + 1;
            end
            if (m_ext) begin
                if (m_cnt == 0) m_unf = 1'b1;
                else            m_cnt = m_cnt - 1;
            end
            if (c) begin
                m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
            end
        end
    endtask

    task automatic cyc(input logic [1:0] s, input logic c, input logic r);
        a = s[1]; b = s[0]; clr = c; reset = r;
        @(posedge clk);
        model_step(s, c, r);
        #1;
        n_ent += int'(enter_tick);
        n_ext += int'(exit_tick);
        n_err += int'(seq_err);
    endtask

    task automatic clear_tallies();
        n_ent = 0; n_ext = 0; n_err = 0;
    endtask

    task automatic walk(input bit dir, input int hold);
        for (int k = 0; k < 4; k++)
            repeat (hold) cyc(pat(dir, k), 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        cyc(2'b00, 1'b0, 1'b1);
        cyc(2'b11, 1'b1, 1'b1);
        checks++;
        if (count !== 8'd0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_count got=%0d/%b/%b exp=0/1/0", count, empty, full);
        end
        checks++;
        if ({enter_tick, exit_tick, seq_err, overflow, underflow} !== 5'b0 ||
            bcd !== 12'h000) begin
            errors++;
            $display("FAIL reset_flags got=%b bcd=%h exp=00000 bcd=000",
                     {enter_tick, exit_tick, seq_err, overflow, underflow}, bcd);
        end
    endtask

    task automatic test_entry();
        clear_tallies();
        walk(1'b0, 3);
        checks++;
        if (n_ent !== 1 || n_ext !== 0) begin
            errors++;
            $display("FAIL entry_ticks got=%0d/%0d exp=1/0", n_ent, n_ext);
        end
        checks++;
        if (count !== 8'd1 || empty !== 1'b0 || bcd !== exp_bcd(1)) begin
            errors++;
            $display("FAIL entry_count got=%0d e=%b bcd=%h exp=1 e=0 bcd=%h",
                     count, empty, bcd, exp_bcd(1));
        end
    endtask

    task automatic test_exit();
        clear_tallies();
        walk(1'b1, 3);
        checks++;
        if (n_ext !== 1 || n_ent !== 0) begin
            errors++;
            $display("FAIL exit_ticks got=%0d/%0d exp=1/0", n_ext, n_ent);
        end
        checks++;
        if (count !== 8'd0 || empty !== 1'b1 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL exit_count got=%0d e=%b u=%b exp=0 e=1 u=0",
                     count, empty, underflow);
        end
    endtask

    task automatic test_backout_error();
        logic [1:0] seq [4] = '{2'b10, 2'b11, 2'b10, 2'b00};
        clear_tallies();
        for (int i = 0; i < 4; i++) repeat (2) cyc(seq[i], 1'b0, 1'b0);
        checks++;
        if (n_ent !== 0 || n_ext !== 0 || count !== 8'd0) begin
            errors++;
            $display("FAIL backout got=%0d/%0d cnt=%0d exp=0/0 cnt=0",
                     n_ent, n_ext, count);
        end
        repeat (2) cyc(2'b00, 1'b0, 1'b0);
        repeat (4) cyc(2'b11, 1'b0, 1'b0);
        checks++;
        if (n_err !== 1 || seq_err !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse got=%0d now=%b exp=1 now=0", n_err, seq_err);
        end
        repeat (2) cyc(2'b01, 1'b0, 1'b0);
        repeat (2) cyc(2'b10, 1'b0, 1'b0);
        checks++;
        if (n_err !== 1 || n_ent !== 0 || n_ext !== 0) begin
            errors++;
            $display("FAIL err_hold got=%0d/%0d/%0d exp=1/0/0", n_err, n_ent, n_ext);
        end
        repeat (2) cyc(2'b00, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        clear_tallies();
        repeat (4) walk(1'b0, 2);
        checks++;
        if (n_ent !== 4) begin
            errors++;
            $display("FAIL sat_ticks got=%0d exp=4", n_ent);
        end
        checks++;
        if (count !== 8'd3 || full !== 1'b1 || overflow !== 1'b1 ||
            bcd !== exp_bcd(3)) begin
            errors++;
            $display("FAIL sat_state got=%0d f=%b o=%b bcd=%h exp=3 f=1 o=1 bcd=%h",
                     count, full, overflow, bcd, exp_bcd(3));
        end
        cyc(2'b00, 1'b1, 1'b0);
        cyc(2'b00, 1'b0, 1'b0);
        checks++;
        if (count !== 8'd0 || overflow !== 1'b0 || full !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL sat_clr got=%0d o=%b f=%b e=%b exp=0 o=0 f=0 e=1",
                     count, overflow, full, empty);
        end
    endtask

    task automatic test_underflow_reset();
        clear_tallies();
        walk(1'b1, 2);
        checks++;
        if (n_ext !== 1 || count !== 8'd0 || underflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow got=%0d cnt=%0d u=%b exp=1 cnt=0 u=1",
                     n_ext, count, underflow);
        end
        clear_tallies();
        repeat (2) cyc(2'b10, 1'b0, 1'b0);
        repeat (2) cyc(2'b11, 1'b0, 1'b0);
        cyc(2'b11, 1'b0, 1'b1);
        repeat (3) cyc(2'b00, 1'b0, 1'b0);
        checks++;
        if (n_ent !== 0 || n_ext !== 0 || n_err !== 0 || count !== 8'd0 ||
            underflow !== 1'b0 || overflow !== 1'b0 || bcd !== 12'h000) begin
            errors++;
            $display("FAIL mid_reset got=%0d/%0d/%0d cnt=%0d u=%b o=%b exp=0/0/0 cnt=0 u=0 o=0",
                     n_ent, n_ext, n_err, count, underflow, overflow);
        end
    endtask

    task automatic test_clr_tick();
        clear_tallies();
        for (int k = 0; k < 3; k++) cyc(pat(1'b0, k), 1'b0, 1'b0);
        cyc(2'b00, 1'b1, 1'b0);
        cyc(2'b00, 1'b0, 1'b0);
        checks++;
        if (n_ent !== 1 || count !== 8'd0) begin
            errors++;
            $display("FAIL clr_tick got=%0d cnt=%0d exp=1 cnt=0", n_ent, count);
        end
    endtask

    task automatic test_random();
        logic [1:0] q[$];
        logic [6:0] got, exp;
        int kind, hold;
        bit dir, c, r;
        cyc(2'b00, 1'b0, 1'b1);
        for (int n = 0; n < 400; n++) begin
            q.delete();
            kind = int'($urandom_range(0, 9));
            dir = (kind >= 4);
            for (int k = 0; k < 4; k++) begin
                logic [1:0] v;
                v = pat(dir, k);
                if (kind >= 8 || $urandom_range(0, 9) == 0) v = 2'($urandom_range(0, 3));
                hold = int'($urandom_range(1, 3));
                repeat (hold) q.push_back(v);
            end
            foreach (q[i]) begin
                c = ($urandom_range(0, 49) == 0);
                r = ($urandom_range(0, 299) == 0);
                cyc(q[i], c, r);
                got = {enter_tick, exit_tick, seq_err, overflow, underflow, full, empty};
                exp = {m_ent, m_ext, m_serr, m_ovf, m_unf, m_cnt == CAP, m_cnt == 0};
                checks++;
                if (count !== 8'(m_cnt)) begin
                    errors++;
                    $display("FAIL rnd_count seq=%0d got=%0d exp=%0d", n, count, m_cnt);
                end
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL rnd_flags seq=%0d got=%b exp=%b", n, got, exp);
                end
                checks++;
                if (bcd !== exp_bcd(m_cnt)) begin
                    errors++;
                    $display("FAIL rnd_bcd seq=%0d got=%h exp=%h", n, bcd, exp_bcd(m_cnt));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_exit();
        test_backout_error();
        test_saturation();
        test_underflow_reset();
        test_clr_tick();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/occupancy_monitor.md
OCCUPANCY_MONITOR -- requirements
Module: occupancy_monitor

Interface
REQ-001 Parameter W, default 8, bit width of the occupancy count.
REQ-002 Parameter CAPACITY, default 200, maximum count; legal range 1..2^W-1 (and at most 999 when OCC_BCD_EN is defined).
REQ-003 clk  input  1  system clock; all logic on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 a  input  1  debounced outer sensor, synchronous to clk, 1 = beam blocked.
REQ-006 b  input  1  debounced inner sensor, synchronous to clk, 1 = beam blocked.
REQ-007 clr  input  1  synchronous clear of the count and the sticky flags.
REQ-008 count  output  W  registered occupancy count.
REQ-009 enter_tick  output  1  registered one-cycle pulse on each completed entry.
REQ-010 exit_tick  output  1  registered one-cycle pulse on each completed exit.
REQ-011 seq_err  output  1  registered one-cycle pulse on an illegal sensor transition.
REQ-012 full  output  1  count == CAPACITY (combinational from count).
REQ-013 empty  output  1  count == 0 (combinational from count).
REQ-014 overflow  output  1  sticky flag: entry attempted while full.
REQ-015 underflow  output  1  sticky flag: exit attempted while empty.
REQ-016 bcd  output  12  3-digit packed BCD copy of count, [11:8] = hundreds.

Function
REQ-017 The FSM SHALL sample s = {a,b} every cycle. It has states IDLE, EN1, EN2, EN3, EX1, EX2, EX3 and ERR.
REQ-018 IDLE transitions: 00 stays; 10 goes to EN1; 01 goes to EX1; 11 goes to ERR.
REQ-019 EN1 transitions: 10 stays; 11 goes to EN2; 00 goes to IDLE (back-out, no count); 01 goes to ERR.
REQ-020 EN2 transitions: 11 stays; 01 goes to EN3; 10 goes to EN1; 00 goes to ERR.
REQ-021 EN3 transitions: 01 stays; 00 goes to IDLE and registers an entry; 11 goes to EN2; 10 goes to ERR.
REQ-022 EX1, EX2 and EX3 SHALL mirror EN1, EN2 and EN3 with a and b swapped. EX3 to IDLE on 00 registers an exit.
REQ-023 ERR SHALL hold until s == 00, then go to IDLE. seq_err SHALL pulse high only in the cycle following entry into ERR.
REQ-024 On an entry edge, enter_tick SHALL be 1 for exactly one cycle. count SHALL increment on that same edge, so both are visible together.
REQ-025 On an exit edge, exit_tick SHALL be 1 for exactly one cycle and count SHALL decrement on the same edge.
REQ-026 Entry while count == CAPACITY: enter_tick still pulses, count holds, overflow sets to 1; no wrap-around.
REQ-027 Exit while count == 0: exit_tick still pulses, count holds, underflow sets to 1; no wrap-around.
REQ-028 clr SHALL set count to 0 and clear overflow and underflow on the next edge. clr overrides a same-cycle entry or exit count update, but ticks still pulse. clr does not affect the FSM.
REQ-029 Entry and exit cannot complete in the same cycle, because there is a single FSM; no arbitration is required.

Reset
REQ-030 On reset, the FSM SHALL go to IDLE.
REQ-031 On reset, count, enter_tick, exit_tick, seq_err, overflow, underflow and bcd SHALL all be 0, so empty = 1 and full = 0.
REQ-032 Reset asserted mid-sequence SHALL abandon the sequence with no tick. After release, the FSM SHALL start from IDLE and evaluate s normally.
REQ-033 reset SHALL take priority over clr and over all other inputs.

Configuration
REQ-034 With OCC_BCD_EN defined, a BCD counter SHALL update in lockstep with count: same edges, same saturation, same clr and reset. bcd always equals count in decimal.
REQ-035 Without OCC_BCD_EN, bcd SHALL be tied to 12'h000 and no BCD logic is synthesised.

Verification
REQ-036 Entry sequence: from reset, drive s = 10, 11, 01, 00 with each held for 3 cycles. Expect one enter_tick, count = 1, empty = 0, bcd = 001 (with OCC_BCD_EN).
REQ-037 Exit sequence: with count = 1, drive s = 01, 11, 10, 00. Expect one exit_tick, count = 0, empty = 1, no underflow.
REQ-038 Back-out and error: drive 10, 11, 10, 00, expecting no tick and count unchanged. Then drive 00, 11, expecting one seq_err pulse; the FSM stays in ERR until 00, with no further pulses.
REQ-039 Saturation: with CAPACITY = 3, perform 4 entries. Expect 4 enter_ticks, count = 3, full = 1, overflow = 1. Then assert clr: count = 0, overflow = 0.
REQ-040 Underflow and reset: perform an exit at count 0, expecting count 0 and underflow = 1. Then assert reset while in EN2 and release it with s = 00: all outputs 0, no tick.
